// File: rtl/sort_host_driver.sv
// Host-side driver for the 8-entry byte sorter:
// stream in, kick the sort, stream the sorted bytes out.
module sort_host_driver #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err_timeout,
  output logic              s_start,
  output logic              s_wr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_datain,
  input  logic [DATA_W-1:0] s_dataout,
  input  logic              s_ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT_LO,
    WAIT_HI,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt;
  logic [TW-1:0]     r_tmo;
  logic [TW-1:0]     w_tmo;
  logic              r_err;
  logic              w_err;
  logic [DATA_W-1:0] r_odata;
  logic [DATA_W-1:0] w_odata;
  logic              r_ovalid;
  logic              w_ovalid;
  logic              r_olast;
  logic              w_olast;
  logic              w_in_ready;
  logic              w_wr;

  // Registers for the FSM, counters and the output stage.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= LOAD;
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_err    <= 1'b0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt;
      r_tmo    <= w_tmo;
      r_err    <= w_err;
      r_odata  <= w_odata;
      r_ovalid <= w_ovalid;
      r_olast  <= w_olast;
    end
  end

  // Next-state logic. The sorter read is synchronous, so the
  // first RD_DATA cycle captures s_dataout and raises out_valid.
  // Acceptance is gated by nrst so no write fires during reset.
  always_comb begin
    w_next     = r_state;
    w_cnt      = r_cnt;
    w_tmo      = r_tmo;
    w_err      = r_err;
    w_odata    = r_odata;
    w_ovalid   = r_ovalid;
    w_olast    = r_olast;
    w_in_ready = nrst & (r_state == LOAD) & s_ready;
    w_wr       = in_valid & w_in_ready;
    unique case (r_state)
      LOAD: begin
        if (w_wr) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt  = '0;
            w_next = START;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      START: begin
        w_tmo  = '0;
        w_next = WAIT_LO;
      end
      WAIT_LO: begin
        w_tmo = r_tmo + 1'b1;
        if (!s_ready) begin
          w_next = WAIT_HI;
        end else if (r_tmo == TMO_LAST) begin
          w_err  = 1'b1;
          w_cnt  = '0;
          w_next = LOAD;
        end
      end
      WAIT_HI: begin
        w_tmo = r_tmo + 1'b1;
        if (s_ready) begin
          w_cnt  = '0;
          w_next = RD_ADDR;
        end else if (r_tmo == TMO_LAST) begin
          w_err  = 1'b1;
          w_cnt  = '0;
          w_next = LOAD;
        end
      end
      RD_ADDR: begin
        w_next = RD_DATA;
      end
      RD_DATA: begin
        if (!r_ovalid) begin
          w_odata  = s_dataout;
          w_ovalid = 1'b1;
          w_olast  = (r_cnt == CNT_LAST);
        end else if (out_ready) begin
          w_ovalid = 1'b0;
          if (r_cnt == CNT_LAST) begin
            w_olast = 1'b0;
            w_cnt   = '0;
            w_next  = LOAD;
          end else begin
            w_cnt  = r_cnt + 1'b1;
            w_next = RD_ADDR;
          end
        end
      end
      default: begin
        w_next = LOAD;
      end
    endcase
  end

  assign in_ready    = w_in_ready;
  assign s_wr        = w_wr;
  assign s_start     = (r_state == START);
  assign s_addr      = r_cnt;
  assign s_datain    = in_data;
  assign out_data    = r_odata;
  assign out_valid   = r_ovalid;
  assign out_last    = r_olast;
  assign err_timeout = r_err;
  assign busy        = !((r_state == LOAD) && (r_cnt == '0));

endmodule
